player_bullet: RTL and testbench

//  Player cannon and single-bullet controller; the producer side of the bullet/hit interface the invader field consumes.

---
 rtl/invaders_pkg.sv | 21 ++
 rtl/player_bullet_tick_divider.sv | 37 +++
 rtl/player_bullet.sv | 153 +++++++++++++++
 tb/tb_player_bullet.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// ---------------------------------------------------------------------------
// invaders_pkg
// Shared definitions for the invaders game blocks: playfield geometry, the
// coordinate widths used on the bullet/hit interface, and the bullet state
// encoding that the field and renderer also decode.
// No ports (package).
// ---------------------------------------------------------------------------
package invaders_pkg;

  localparam int GRID_W = 20;
  localparam int GRID_H = 16;
  localparam int X_W    = 5;
  localparam int Y_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    RETIRE
  } bullet_state_t;

endpackage

// File: rtl/player_bullet_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Free-running clock divider producing a one-cycle tick every PERIOD cycles.
// The counter runs 0..PERIOD-1 and the tick is high while it sits at PERIOD-1,
// so the first tick after reset lands on the PERIOD-th clock.
// Ports:
//   clk_36MHz  in  1  system clock
//   reset      in  1  asynchronous reset, active low
//   tick       out 1  one-cycle pulse every PERIOD cycles
// ---------------------------------------------------------------------------
module tick_divider #(
  parameter int PERIOD = 72000
) (
  input  logic clk_36MHz,
  input  logic reset,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // Count up and wrap to zero on the last value of the period.
  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/player_bullet.sv
// ---------------------------------------------------------------------------
// player_bullet
// Player cannon and single-bullet controller. Moves the cannon along the
// bottom row from the buttons, launches one bullet per fire press, steps it up
// one row per bullet tick, and retires it on a hit pulse from the invader
// field or when it leaves the top row.
// Optional feature macro: SCORE_COUNTER_EN (builds the saturating hit counter;
// without it score is tied to zero).
// Ports:
//   clk_36MHz      in  1  system clock
//   reset          in  1  asynchronous reset, active low
//   btn_left       in  1  move cannon toward column 0 (level)
//   btn_right      in  1  move cannon toward X_MAX (level)
//   btn_fire       in  1  fire request (level, rising edge used)
//   hit            in  1  registered invader hit pulse
//   player_x       out 5  cannon column
//   bullet_x       out 5  bullet column
//   bullet_y       out 4  bullet row
//   bullet_active  out 1  bullet in flight
//   score          out 8  saturating hit count
// ---------------------------------------------------------------------------
module player_bullet
  import invaders_pkg::*;
#(
  parameter int BULLET_PERIOD = 72000,
  parameter int MOVE_PERIOD   = 1800000,
  parameter int X_MAX         = 19,
  parameter int Y_START       = 14
) (
  input  logic           clk_36MHz,
  input  logic           reset,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_fire,
  input  logic           hit,
  output logic [X_W-1:0] player_x,
  output logic [X_W-1:0] bullet_x,
  output logic [Y_W-1:0] bullet_y,
  output logic           bullet_active,
  output logic [7:0]     score
);

  localparam logic [X_W-1:0] X_LIMIT = X_W'(X_MAX);
  localparam logic [X_W-1:0] X_HOME  = X_W'(X_MAX / 2);
  localparam logic [Y_W-1:0] Y_INIT  = Y_W'(Y_START);

  bullet_state_t state;
  logic          bullet_tick;
  logic          move_tick;
  logic          fire_q;
  logic          fire_rise;

  tick_divider #(.PERIOD(BULLET_PERIOD)) u_bullet_div (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .tick      (bullet_tick)
  );

  tick_divider #(.PERIOD(MOVE_PERIOD)) u_move_div (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .tick      (move_tick)
  );

  // Fire edge detect so a held button launches only once.
  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      fire_q <= 1'b0;
    end else begin
      fire_q <= btn_fire;
    end
  end

  assign fire_rise = btn_fire & ~fire_q;

  // Cannon: steps on move_tick only when exactly one direction is held,
  // saturating at both edges of the grid.
  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      player_x <= X_HOME;
    end else if (move_tick) begin
      if (btn_left && !btn_right && (player_x != '0)) begin
        player_x <= player_x - 1'b1;
      end else if (btn_right && !btn_left && (player_x != X_LIMIT)) begin
        player_x <= player_x + 1'b1;
      end
    end
  end

  // Bullet FSM. Entering RETIRE drops bullet_active at once but leaves the
  // coordinates where they were for that one cycle; RETIRE then parks them at
  // row/column 0 (row 0 never matches the field compare) and returns to IDLE.
  // Hit wins over a coincident bullet tick.
  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bullet_active <= 1'b0;
          if (fire_rise) begin
            state         <= FLYING;
            bullet_x      <= player_x;
            bullet_y      <= Y_INIT;
            bullet_active <= 1'b1;
          end
        end
        FLYING: begin
          if (hit) begin
            state         <= RETIRE;
            bullet_active <= 1'b0;
          end else if (bullet_tick) begin
            if (bullet_y == '0) begin
              state         <= RETIRE;
              bullet_active <= 1'b0;
            end else begin
              bullet_y <= bullet_y - 1'b1;
            end
          end
        end
        RETIRE: begin
          state         <= IDLE;
          bullet_x      <= '0;
          bullet_y      <= '0;
          bullet_active <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bullet_x      <= '0;
          bullet_y      <= '0;
          bullet_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_COUNTER_EN
  // Count hits that land on a bullet in flight, holding at 255.
  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      score <= 8'd0;
    end else if ((state == FLYING) && hit && (score != 8'hFF)) begin
      score <= score + 8'd1;
    end
  end
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_player_bullet.sv
// ---------------------------------------------------------------------------
// tb_player_bullet
// Self-checking bench for player_bullet with short divider periods. A
// behavioural model tracks the cannon column, the bullet as "in flight" /
// "retiring" flags with a row/column, and the hit count, and every clock
// compares all outputs against it. Directed scenarios are followed by a
// randomized run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_player_bullet;

  localparam int BP      = 5;
  localparam int MP      = 3;
  localparam int X_MAX   = 19;
  localparam int Y_START = 14;
`ifdef SCORE_COUNTER_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic       clk_36MHz = 1'b0;
  logic       reset     = 1'b0;
  logic       btn_left  = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_fire  = 1'b0;
  logic       hit       = 1'b0;
  logic [4:0] player_x;
  logic [4:0] bullet_x;
  logic [3:0] bullet_y;
  logic       bullet_active;
  logic [7:0] score;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int m_player, m_bx, m_by, m_score, m_cyc;
  bit m_active, m_retiring, m_fire_prev;

  player_bullet #(
    .BULLET_PERIOD (BP),
    .MOVE_PERIOD   (MP),
    .X_MAX         (X_MAX),
    .Y_START       (Y_START)
  ) dut (
    .clk_36MHz     (clk_36MHz),
    .reset         (reset),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_fire      (btn_fire),
    .hit           (hit),
    .player_x      (player_x),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .score         (score)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  task automatic modelReset();
    m_player    = X_MAX / 2;
    m_bx        = 0;
    m_by        = 0;
    m_score     = 0;
    m_cyc       = 0;
    m_active    = 1'b0;
    m_retiring  = 1'b0;
    m_fire_prev = 1'b0;
  endtask

  // One clock edge of the game rules, using the inputs present at the edge.
  task automatic modelEdge();
    bit bt, mt, fr;
    bt = (m_cyc % BP) == BP - 1;
    mt = (m_cyc % MP) == MP - 1;
    m_cyc++;
    fr = btn_fire && !m_fire_prev;
    m_fire_prev = btn_fire;
    if (m_retiring) begin
      m_retiring = 1'b0;
      m_active   = 1'b0;
      m_bx       = 0;
      m_by       = 0;
    end else if (m_active) begin
      if (hit) begin
        m_active   = 1'b0;
        m_retiring = 1'b1;
        if (SCORE_EN && m_score < 255) m_score++;
      end else if (bt) begin
        if (m_by == 0) begin
          m_active   = 1'b0;
          m_retiring = 1'b1;
        end else begin
          m_by--;
        end
      end
    end else if (fr) begin
      m_active = 1'b1;
      m_bx     = m_player;
      m_by     = Y_START;
    end
    if (mt && btn_left && !btn_right && m_player > 0) m_player--;
    else if (mt && btn_right && !btn_left && m_player < X_MAX) m_player++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_player_x"}, 32'(player_x), 32'(m_player));
    check({tag, "_bullet_x"}, 32'(bullet_x), 32'(m_bx));
    check({tag, "_bullet_y"}, 32'(bullet_y), 32'(m_by));
    check({tag, "_active"}, 32'(bullet_active), 32'(m_active));
    check({tag, "_score"}, 32'(score), 32'(m_score));
  endtask

  // Drive inputs, take one clock, advance the model and compare #1 later.
  task automatic applyStimulus(input bit l, input bit r, input bit f, input bit h, input string tag);
    btn_left  = l;
    btn_right = r;
    btn_fire  = f;
    hit       = h;
    @(posedge clk_36MHz);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic timeoutFail(input string tag);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: wait bound expired", tag);
  endtask

  initial begin
    int guard;
    bit l, r, f, h;

    $display("[TB] start, SCORE_EN=%0d", SCORE_EN);
    modelReset();
    repeat (3) @(negedge clk_36MHz);
    checkOutput("reset");
    reset = 1'b1;

    // 1: hold right for 12 move ticks, saturating at X_MAX
    repeat (12 * MP) applyStimulus(0, 1, 0, 0, "move_right");
    check("right_saturated", 32'(player_x), 32'(X_MAX));

    // 2: walk to column 5, fire, then move the cannon away
    guard = 0;
    while (m_player != 5 && guard < 200) begin
      applyStimulus(1, 0, 0, 0, "move_left");
      guard++;
    end
    if (m_player != 5) timeoutFail("reach_col5");
    applyStimulus(0, 0, 1, 0, "fire");
    check("launch_x", 32'(bullet_x), 32'd5);
    check("launch_y", 32'(bullet_y), 32'(Y_START));
    check("launch_active", 32'(bullet_active), 32'd1);
    repeat (3 * MP) applyStimulus(0, 1, 0, 0, "fly_move");
    check("bullet_x_frozen", 32'(bullet_x), 32'd5);

    // 3: no hit, bullet climbs to row 0 and leaves the top
    guard = 0;
    while ((m_active || m_retiring) && guard < 200) begin
      applyStimulus(0, 0, 0, 0, "climb");
      guard++;
    end
    if (m_active || m_retiring) timeoutFail("top_exit");
    check("idle_after_exit_y", 32'(bullet_y), 32'd0);
    check("idle_after_exit_active", 32'(bullet_active), 32'd0);

    // 4: hit coincident with a bullet tick at row 3
    applyStimulus(0, 0, 1, 0, "fire2");
    guard = 0;
    while (!(m_active && m_by == 3 && (m_cyc % BP) == BP - 1) && guard < 300) begin
      applyStimulus(0, 0, 0, 0, "wait_row3");
      guard++;
    end
    if (!(m_active && m_by == 3)) timeoutFail("reach_row3");
    applyStimulus(0, 0, 0, 1, "hit_tick");
    check("hit_holds_row", 32'(bullet_y), 32'd3);
    check("hit_clears_active", 32'(bullet_active), 32'd0);
    applyStimulus(0, 0, 0, 0, "retire");
    check("retire_parks_y", 32'(bullet_y), 32'd0);
    check("score_after_hit", 32'(score), SCORE_EN ? 32'd1 : 32'd0);

    // 5: held fire launches once; fire edges in flight and retire are dropped
    applyStimulus(0, 0, 1, 0, "held_fire");
    guard = 0;
    while ((m_active || m_retiring) && guard < 200) begin
      applyStimulus(0, 0, 1, 0, "held_fly");
      guard++;
    end
    repeat (4) applyStimulus(0, 0, 1, 0, "held_idle");
    check("held_no_relaunch", 32'(bullet_active), 32'd0);
    applyStimulus(0, 0, 0, 0, "release");
    applyStimulus(0, 0, 1, 0, "refire");
    applyStimulus(0, 0, 0, 0, "fly_release");
    applyStimulus(0, 0, 1, 0, "fly_edge");
    check("fly_edge_ignored_y", 32'(bullet_y), 32'(m_by));
    applyStimulus(0, 0, 0, 1, "hit_release");
    applyStimulus(0, 0, 1, 0, "retire_edge");
    repeat (3) applyStimulus(0, 0, 1, 0, "after_retire_edge");
    check("retire_edge_dropped", 32'(bullet_active), 32'd0);
    applyStimulus(0, 0, 0, 0, "release2");

    // 6: asynchronous reset mid-flight at row 7
    applyStimulus(0, 0, 1, 0, "fire3");
    guard = 0;
    while (!(m_active && m_by == 7) && guard < 300) begin
      applyStimulus(0, 0, 0, 0, "wait_row7");
      guard++;
    end
    if (!(m_active && m_by == 7)) timeoutFail("reach_row7");
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clk_36MHz);
    reset = 1'b1;

    // Saturation: 256 accepted hits, then one more
    for (int i = 0; i < 257; i++) begin
      applyStimulus(0, 0, 1, 0, "sat_fire");
      applyStimulus(0, 0, 0, 1, "sat_hit");
      applyStimulus(0, 0, 0, 0, "sat_retire");
    end
    check("score_saturated", 32'(score), SCORE_EN ? 32'd255 : 32'd0);
    applyStimulus(0, 0, 0, 1, "idle_hit");
    check("idle_hit_ignored", 32'(score), SCORE_EN ? 32'd255 : 32'd0);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 2) == 0);
      h = ($urandom_range(0, 5) == 0);
      applyStimulus(l, r, f, h, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
